// File: rtl/cache_req_sequencer.sv
// Trace-driven request generator for the cache CPU-side port: replays a loaded
// read/write trace, stalls on miss, checks returned read data and keeps statistics.
module cache_req_sequencer #(
  parameter int TRACE_AW = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [TRACE_AW-1:0] load_idx,
  input  logic                load_wr,
  input  logic                load_chk,
  input  logic [31:0]         load_addr,
  input  logic [31:0]         load_data,
  input  logic [TRACE_AW:0]   trace_len,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [31:0]         addr,
  output logic                rd_req,
  output logic                wr_req,
  output logic [31:0]         wr_data,
  input  logic                miss,
  input  logic [31:0]         rd_data,
  output logic [31:0]         req_cnt,
  output logic [31:0]         miss_cnt,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         cycle_cnt,
  output logic [15:0]         err_cnt,
  output logic [TRACE_AW-1:0] first_err_idx
);

  localparam int DEPTH = 1 << TRACE_AW;
  localparam int LW    = TRACE_AW + 1;
  localparam int WDW   = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]      WDOG_LIMIT = WDW'(TIMEOUT);
  localparam logic [WDW-1:0]      WDOG_ZERO  = WDW'(0);
  localparam logic [WDW-1:0]      WDOG_ONE   = WDW'(1);
  localparam logic [LW-1:0]       LEN_ZERO   = LW'(0);
  localparam logic [LW-1:0]       LEN_ONE    = LW'(1);
  localparam logic [TRACE_AW-1:0] IDX_ZERO   = TRACE_AW'(0);
  localparam logic [TRACE_AW-1:0] IDX_ONE    = TRACE_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                mem_wr_q   [DEPTH];
  logic                mem_chk_q  [DEPTH];
  logic [31:0]         mem_addr_q [DEPTH];
  logic [31:0]         mem_data_q [DEPTH];

  state_t              state_q, state_d;
  logic [TRACE_AW-1:0] idx_q, idx_d;
  logic [LW-1:0]       len_q, len_d;
  logic [WDW-1:0]      wdog_q, wdog_d;
  logic                first_q, first_d;
  logic                timeout_q, timeout_d;
  logic [31:0]         req_cnt_q, req_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [TRACE_AW-1:0] fei_q, fei_d;
  logic                busy_q, done_q, rd_req_q, wr_req_q;
  logic [31:0]         addr_q, wr_data_q;

  logic                cur_wr_s, cur_chk_s, last_s;
  logic [31:0]         cur_data_s;
  logic [WDW-1:0]      wdog_inc_s;
  logic                fwd_s, nxt_wr_s, issue_d_s;
  logic [31:0]         nxt_addr_s, nxt_data_s;

  assign cur_wr_s   = mem_wr_q[idx_q];
  assign cur_chk_s  = mem_chk_q[idx_q];
  assign cur_data_s = mem_data_q[idx_q];
  assign last_s     = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign wdog_inc_s = wdog_q + WDOG_ONE;

  // Outputs are registered from the next state, so the entry at idx_d is needed;
  // a load landing on that slot in the same cycle as start is forwarded.
  assign fwd_s      = (state_q == S_IDLE) && load_en && (load_idx == idx_d);
  assign nxt_wr_s   = fwd_s ? load_wr   : mem_wr_q[idx_d];
  assign nxt_addr_s = fwd_s ? load_addr : mem_addr_q[idx_d];
  assign nxt_data_s = fwd_s ? load_data : mem_data_q[idx_d];
  assign issue_d_s  = (state_d == S_ISSUE);

  // Trace storage, writable only while idle.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && load_en) begin
      mem_wr_q[load_idx]   <= load_wr;
      mem_chk_q[load_idx]  <= load_chk;
      mem_addr_q[load_idx] <= load_addr;
      mem_data_q[load_idx] <= load_data;
    end
  end

  // Next-state and statistics update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    wdog_d      = wdog_q;
    first_d     = first_q;
    timeout_d   = timeout_q;
    req_cnt_d   = req_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    stall_cnt_d = stall_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    err_cnt_d   = err_cnt_q;
    fei_d       = fei_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (trace_len == LEN_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ISSUE;
            idx_d       = IDX_ZERO;
            len_d       = trace_len;
            wdog_d      = WDOG_ZERO;
            first_d     = 1'b1;
            timeout_d   = 1'b0;
            req_cnt_d   = 32'd0;
            miss_cnt_d  = 32'd0;
            stall_cnt_d = 32'd0;
            cycle_cnt_d = 32'd0;
            err_cnt_d   = 16'd0;
            fei_d       = IDX_ZERO;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cycle_cnt_d = sat_inc32(cycle_cnt_q);
        if (miss) begin
          stall_cnt_d = sat_inc32(stall_cnt_q);
          wdog_d      = wdog_inc_s;
          first_d     = 1'b0;
          // A miss is counted once per entry, on its first issue cycle only.
          if (first_q) begin
            miss_cnt_d = sat_inc32(miss_cnt_q);
          end else begin
            miss_cnt_d = miss_cnt_q;
          end
          if (wdog_inc_s == WDOG_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          req_cnt_d = sat_inc32(req_cnt_q);
          wdog_d    = WDOG_ZERO;
          if (cur_wr_s) begin
            if (last_s) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              first_d = 1'b1;
              state_d = S_ISSUE;
            end
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        cycle_cnt_d = sat_inc32(cycle_cnt_q);
        if (cur_chk_s && (rd_data != cur_data_s)) begin
          err_cnt_d = sat_inc16(err_cnt_q);
          if (err_cnt_q == 16'd0) begin
            fei_d = idx_q;
          end else begin
            fei_d = fei_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          first_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, statistics and registered cache-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= IDX_ZERO;
      len_q       <= LEN_ZERO;
      wdog_q      <= WDOG_ZERO;
      first_q     <= 1'b0;
      timeout_q   <= 1'b0;
      req_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
      cycle_cnt_q <= 32'd0;
      err_cnt_q   <= 16'd0;
      fei_q       <= IDX_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      addr_q      <= 32'd0;
      wr_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      wdog_q      <= wdog_d;
      first_q     <= first_d;
      timeout_q   <= timeout_d;
      req_cnt_q   <= req_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_cnt_q   <= err_cnt_d;
      fei_q       <= fei_d;
      busy_q      <= (state_d == S_ISSUE) || (state_d == S_CHECK);
      done_q      <= (state_d == S_DONE);
      rd_req_q    <= issue_d_s && !nxt_wr_s;
      wr_req_q    <= issue_d_s && nxt_wr_s;
      addr_q      <= issue_d_s ? nxt_addr_s : 32'd0;
      wr_data_q   <= issue_d_s ? nxt_data_s : 32'd0;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign addr          = addr_q;
  assign rd_req        = rd_req_q;
  assign wr_req        = wr_req_q;
  assign wr_data       = wr_data_q;
  assign req_cnt       = req_cnt_q;
  assign miss_cnt      = miss_cnt_q;
  assign stall_cnt     = stall_cnt_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = fei_q;

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Bench for cache_req_sequencer: a small cache model answers requests, and a
// scoreboard of expected requests is checked against each accepted request.
module tb_cache_req_sequencer;
  localparam int AW = 8;
  localparam int TO = 16;

  typedef struct packed {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en, load_wr, load_chk, start;
  logic [AW-1:0] load_idx;
  logic [31:0]   load_addr, load_data;
  logic [AW:0]   trace_len;
  logic          busy, done, timeout, rd_req, wr_req, miss;
  logic [31:0]   addr, wr_data, rd_data;
  logic [31:0]   req_cnt, miss_cnt, stall_cnt, cycle_cnt;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_idx;

  int checks = 0;
  int errors = 0;
  int last_wait, req_cycles;
  exp_t exp_q[$];
  bit          t_wr   [16];
  logic [31:0] t_addr [16];
  logic [31:0] t_data [16];

  // Cache model state
  logic        present [256];
  logic [31:0] cmem    [256];
  int          mcnt = 0;
  int          miss_lat = 2;
  bit          clr_cache = 1'b0, force_miss = 1'b0, zero_rd = 1'b0;
  logic [7:0]  line_s;

  always #5 clk = ~clk;

  cache_req_sequencer #(.TRACE_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx),
    .load_wr(load_wr), .load_chk(load_chk), .load_addr(load_addr),
    .load_data(load_data), .trace_len(trace_len), .start(start),
    .busy(busy), .done(done), .timeout(timeout), .addr(addr),
    .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data), .miss(miss),
    .rd_data(rd_data), .req_cnt(req_cnt), .miss_cnt(miss_cnt),
    .stall_cnt(stall_cnt), .cycle_cnt(cycle_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx)
  );

  assign line_s = addr[9:2];
  assign miss   = (rd_req | wr_req) & (force_miss | ~present[line_s]);

  // Word-line cache: a miss lasts miss_lat cycles, then the line is filled.
  always @(posedge clk) begin
    if (clr_cache) begin
      for (int i = 0; i < 256; i++) present[i] <= 1'b0;
      mcnt <= 0;
    end else if ((rd_req || wr_req) && !force_miss && !present[line_s]) begin
      if (mcnt >= miss_lat - 1) begin
        present[line_s] <= 1'b1;
        mcnt <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
    if ((rd_req || wr_req) && !miss) begin
      if (wr_req) cmem[line_s] <= wr_data;
      rd_data <= (rd_req && !zero_rd) ? cmem[line_s] : 32'h0;
    end else begin
      rd_data <= 32'h0;
    end
  end

  task automatic cold();
    @(negedge clk) clr_cache = 1'b1;
    @(negedge clk) clr_cache = 1'b0;
  endtask

  task automatic load(input int idx, input bit wr, input bit chk,
                      input logic [31:0] a, input logic [31:0] d);
    t_wr[idx] = wr; t_addr[idx] = a; t_data[idx] = d;
    @(negedge clk);
    load_en = 1'b1; load_idx = idx[AW-1:0]; load_wr = wr; load_chk = chk;
    load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run(input int n, input bit poke, input bit aborts);
    int i; bit seen; bit pend; logic [65:0] prev; exp_t e;
    for (int k = 0; k < n; k++) exp_q.push_back({t_wr[k], t_addr[k], t_data[k]});
    @(negedge clk);
    trace_len = n[AW:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0; seen = 1'b0; pend = 1'b0; req_cycles = 0; prev = 66'h0;
    while (!seen && i < 500) begin
      if (done) begin
        seen = 1'b1; last_wait = i;
      end else begin
        if (rd_req || wr_req) begin
          req_cycles++;
          if (pend) begin
            checks++;
            if ({rd_req, wr_req, addr, wr_data} !== prev) begin
              errors++;
              $display("FAIL hold: request changed during miss, got %h want %h",
                       {rd_req, wr_req, addr, wr_data}, prev);
            end
          end
          prev = {rd_req, wr_req, addr, wr_data};
          pend = miss;
          if (!miss) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL sb_extra: unexpected request addr %h wr %b", addr, wr_req);
            end else begin
              e = exp_q.pop_front();
              if (wr_req !== e.wr || rd_req !== !e.wr || addr !== e.a || (e.wr && wr_data !== e.d)) begin
                errors++;
                $display("FAIL sb_req: got wr=%b rd=%b a=%h d=%h want wr=%b a=%h d=%h",
                         wr_req, rd_req, addr, wr_data, e.wr, e.a, e.d);
              end
            end
          end
        end else begin
          pend = 1'b0;
        end
        if (poke && i == 0) begin
          load_en = 1'b1; load_idx = 8'd2; load_wr = 1'b0; load_addr = 32'hBAD0;
          start = 1'b1; trace_len = 9'd1;
        end else if (poke && i == 1) begin
          load_en = 1'b0; start = 1'b0;
        end
        @(negedge clk);
        i++;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_seen: no done within 500 cycles, want a done pulse"); end
    @(negedge clk);
    checks++;
    if ({done, busy, rd_req, wr_req} !== 4'b0) begin
      errors++;
      $display("FAIL done_once: done/busy/rd/wr got %b want 0000", {done, busy, rd_req, wr_req});
    end
    if (aborts) begin
      exp_q.delete();
    end else begin
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL sb_left: %0d requests missing, want 0", exp_q.size()); end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, timeout, rd_req, wr_req} !== 5'b0 || {addr, wr_data} !== 64'h0) begin
      errors++; $display("FAIL reset_out: flags %b addr %h data %h want 0", {busy, done, timeout, rd_req, wr_req}, addr, wr_data);
    end
    checks++;
    if ({req_cnt, miss_cnt, stall_cnt, cycle_cnt, err_cnt, first_err_idx} !== 152'h0) begin
      errors++; $display("FAIL reset_cnt: req/miss/stall/cycle/err/fei %0d/%0d/%0d/%0d/%0d/%0d want 0",
                         req_cnt, miss_cnt, stall_cnt, cycle_cnt, err_cnt, first_err_idx);
    end
  endtask

  task automatic test_zero_len();
    run(0, 1'b0, 1'b0);
    checks++;
    if (last_wait != 0 || req_cycles != 0) begin
      errors++; $display("FAIL zero_len: wait %0d reqs %0d want 0 0", last_wait, req_cycles);
    end
    checks++;
    if ({req_cnt, cycle_cnt} !== 64'h0) begin
      errors++; $display("FAIL zero_len_cnt: req %0d cycle %0d want 0 0", req_cnt, cycle_cnt);
    end
  endtask

  task automatic test_basic();
    cold(); miss_lat = 2;
    load(0, 1'b1, 1'b0, 32'h10, 32'hA5);
    load(1, 1'b0, 1'b1, 32'h10, 32'hA5);
    load(2, 1'b1, 1'b0, 32'h14, 32'h1);
    load(3, 1'b0, 1'b1, 32'h14, 32'h1);
    run(4, 1'b0, 1'b0);
    checks++;
    if (last_wait != 10) begin errors++; $display("FAIL basic_wait: done after %0d want 10", last_wait); end
    checks++;
    if ({req_cnt, miss_cnt, stall_cnt, cycle_cnt} !== {32'd4, 32'd2, 32'd4, 32'd10}) begin
      errors++; $display("FAIL basic_stats: req/miss/stall/cycle %0d/%0d/%0d/%0d want 4/2/4/10",
                         req_cnt, miss_cnt, stall_cnt, cycle_cnt);
    end
    checks++;
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL basic_err: err %0d want 0", err_cnt); end
  endtask

  task automatic test_back_to_back();
    load(0, 1'b1, 1'b0, 32'h10, 32'h1);
    load(1, 1'b1, 1'b0, 32'h14, 32'h2);
    load(2, 1'b1, 1'b0, 32'h10, 32'h3);
    run(3, 1'b1, 1'b0);
    checks++;
    if (last_wait != 3 || req_cycles != 3) begin
      errors++; $display("FAIL b2b_wait: done after %0d reqs %0d want 3 3", last_wait, req_cycles);
    end
    checks++;
    if ({req_cnt, miss_cnt, stall_cnt, cycle_cnt} !== {32'd3, 32'd0, 32'd0, 32'd3}) begin
      errors++; $display("FAIL b2b_stats: req/miss/stall/cycle %0d/%0d/%0d/%0d want 3/0/0/3",
                         req_cnt, miss_cnt, stall_cnt, cycle_cnt);
    end
  endtask

  task automatic test_mismatch();
    cold(); miss_lat = 2; zero_rd = 1'b1;
    load(0, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF);
    run(1, 1'b0, 1'b0);
    checks++;
    if (err_cnt !== 16'd1 || first_err_idx !== 8'd0 || req_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL mis_single: err %0d fei %0d req %0d miss %0d want 1 0 1 1",
                         err_cnt, first_err_idx, req_cnt, miss_cnt);
    end
    load(0, 1'b0, 1'b0, 32'h20, 32'h55);
    load(1, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF);
    run(2, 1'b0, 1'b0);
    checks++;
    if (err_cnt !== 16'd1 || first_err_idx !== 8'd1 || req_cnt !== 32'd2 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL mis_second: err %0d fei %0d req %0d miss %0d want 1 1 2 0",
                         err_cnt, first_err_idx, req_cnt, miss_cnt);
    end
    zero_rd = 1'b0;
  endtask

  task automatic test_stall();
    cold(); miss_lat = 5;
    load(0, 1'b1, 1'b0, 32'h30, 32'h77);
    run(1, 1'b0, 1'b0);
    checks++;
    if (req_cycles != 6 || last_wait != 6) begin
      errors++; $display("FAIL stall_len: req cycles %0d done %0d want 6 6", req_cycles, last_wait);
    end
    checks++;
    if ({req_cnt, miss_cnt, stall_cnt} !== {32'd1, 32'd1, 32'd5}) begin
      errors++; $display("FAIL stall_stats: req/miss/stall %0d/%0d/%0d want 1/1/5", req_cnt, miss_cnt, stall_cnt);
    end
  endtask

  task automatic test_timeout();
    force_miss = 1'b1;
    load(0, 1'b0, 1'b1, 32'h40, 32'h0);
    run(1, 1'b0, 1'b1);
    force_miss = 1'b0;
    checks++;
    if (timeout !== 1'b1 || last_wait != 16 || req_cycles != 16) begin
      errors++; $display("FAIL timeout: flag %b done %0d reqs %0d want 1 16 16", timeout, last_wait, req_cycles);
    end
    checks++;
    if ({req_cnt, miss_cnt, stall_cnt, cycle_cnt} !== {32'd0, 32'd1, 32'd16, 32'd16}) begin
      errors++; $display("FAIL to_stats: req/miss/stall/cycle %0d/%0d/%0d/%0d want 0/1/16/16",
                         req_cnt, miss_cnt, stall_cnt, cycle_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    cold(); miss_lat = 4;
    load(0, 1'b1, 1'b0, 32'h50, 32'hC3);
    load(1, 1'b0, 1'b0, 32'h58, 32'h0);
    load(2, 1'b0, 1'b1, 32'h50, 32'hC3);
    @(negedge clk);
    trace_len = 9'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (rd_req !== 1'b1 || miss !== 1'b1 || addr !== 32'h58) begin
      errors++; $display("FAIL pre_rst: rd %b miss %b addr %h want 1 1 00000058", rd_req, miss, addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_req, wr_req, busy, done, timeout} !== 5'b0 || addr !== 32'h0 ||
        {req_cnt, miss_cnt, stall_cnt, cycle_cnt} !== 128'h0) begin
      errors++; $display("FAIL async_rst: flags %b addr %h req %0d stall %0d cycle %0d want 0",
                         {rd_req, wr_req, busy, done, timeout}, addr, req_cnt, stall_cnt, cycle_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cold();
    run(3, 1'b0, 1'b0);
    checks++;
    if (last_wait != 13 || {req_cnt, miss_cnt, stall_cnt, cycle_cnt} !== {32'd3, 32'd2, 32'd8, 32'd13} ||
        err_cnt !== 16'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL rerun: done %0d req/miss/stall/cycle %0d/%0d/%0d/%0d err %0d to %b want 13 3/2/8/13 0 0",
                         last_wait, req_cnt, miss_cnt, stall_cnt, cycle_cnt, err_cnt, timeout);
    end
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_idx = 8'd0; load_wr = 1'b0; load_chk = 1'b0;
    load_addr = 32'h0; load_data = 32'h0; trace_len = 9'd0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_zero_len();
    test_basic();
    test_back_to_back();
    test_mismatch();
    test_stall();
    test_timeout();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
